alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised execute unit for the multicycle RISC-V core: a superset of the basic four-op ALU that adds the full RV32I integer op set and the M-extension multiply/divide ops. Single-cycle ops complete one cycle after `start`. Multiply/divide ops run iteratively, one bit per cycle, behind a start/busy/done handshake. The control FSM issues one op at a time and waits for `done` before writing back.

## Interface
- `WIDTH`, 32: datapath width. Power of two, ≥ 8.
- `ENABLE_MDU`, 1: 1 = multiply/divide implemented. 0 = MDU codes behave as unknown codes.

- `clk`  in  1  clock, all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; samples `ctrl`, `a`, `b`
- `ctrl`  in  5  op code, see Operation
- `a`, `b`  in  WIDTH  operands
- `busy`  out  1  iterative op in progress; `start` ignored while high
- `done`  out  1  one-cycle pulse, `y` valid and updated
- `y`  out  WIDTH  registered result, held until next completion
- `zero`  out  1  `y == 0`, combinational from `y`

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU. Result is 1 or 0, zero-extended.
  - 7 SLL, 8 SRL, 9 SRA. Shift amount is `b[log2(WIDTH)-1:0]`.
  - 16 MUL (low half), 17 MULH (s×s high), 18 MULHSU (signed a × unsigned b, high), 19 MULHU (high).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code gives `y = 0` via the single-cycle path.
- All arithmetic is modulo 2^WIDTH. No overflow or carry outputs.
- FSM states: IDLE, CALC, FIN.
  - IDLE + `start` + single-cycle op: `y` written, `done` = 1 next cycle, remain in IDLE.
  - IDLE + `start` + MDU op: latch operand magnitudes and sign flags, counter = 0, go to CALC.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After WIDTH steps, go to FIN.
  - FIN: apply sign correction, write `y`, pulse `done`, go to IDLE.
- Division corner cases (RISC-V semantics; override the result at FIN, same latency):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = most-negative; remainder = 0.
- Remainder takes the sign of the dividend. Quotient rounds toward zero.
- `busy` = (state ≠ IDLE).
- Reset mid-operation abandons the op. No `done` is raised for it.

## Timing
- Reset values: state IDLE, `y` = 0 (so `zero` = 1), `done` = 0, `busy` = 0, counter = 0.
- Numbering: `start` is high in cycle 0.
- Single-cycle op: `done` = 1 and new `y` in cycle 1.
- MDU op:
  - `busy` high in cycles 1..WIDTH+1 (CALC for cycles 1..WIDTH, FIN in cycle WIDTH+1).
  - `done` = 1 and new `y` in cycle WIDTH+2, with `busy` = 0 in that cycle.
- `start` in a cycle where `done` = 1 is accepted; back-to-back issue is allowed.
- `start` while `busy` = 1 is dropped silently. Latched operands are unaffected.
- `a`, `b`, `ctrl` need only be valid in the `start` cycle.
- `y` and `zero` are stable between `done` pulses.

## Test plan
- Basic ALU ops, WIDTH = 32:
  - ADD 5+7 → cycle 1: `done` = 1, `y` = 12, `zero` = 0.
  - SUB 7−7 → `y` = 0, `zero` = 1.
  - Code 31 → `y` = 0.
- Shifts and compares:
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL with same operands → 0x08000000.
  - SLL with `b` = 0x24 → shift by 4 (amount is `b[4:0]`).
  - SLT(−1, 1) → 1; SLTU(−1, 1) → 0.
- Multiply, a = 0xFFFFFFFF, b = 2:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001.
  - MULHSU(−1, 2) → 0xFFFFFFFF.
  - `busy` high cycles 1..33, `done` in cycle 34.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 13/0 → 0xFFFFFFFF; REMU 13/0 → 13.
  - DIV 0x80000000 / −1 → 0x80000000; REM same operands → 0.
- Handshake and reset:
  - `start` during `busy` → ignored; the original result is delivered unchanged.
  - `start` in the `done` cycle → second op accepted.
  - `reset` in cycle 10 of a DIV → `busy` = 0 and `y` = 0 next cycle; no `done`.
- Parametrisation:
  - WIDTH = 16: MULHU 0xFFFF×0xFFFF → 0xFFFE, `done` in cycle 18.
  - ENABLE_MDU = 0: MUL → `y` = 0, `done` in cycle 1.

Source files
------------

// File: rtl/alu_mdu.sv
// Execute unit: single-cycle RV32I ALU ops plus iterative (one bit per cycle)
// M-extension multiply/divide behind a start/busy/done handshake.
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [1:0]       fsm_state
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;
  state_t state, state_next;

  logic [SW-1:0]    cnt;
  logic [2:0]       op;
  logic             neg_q, neg_r, b_zero;
  logic [WIDTH-1:0] mcand, hi, lo;

  // Handshake: start is taken only in IDLE (busy low); done pulses for exactly
  // one cycle with y already updated; a start during busy is dropped.
  logic accept, mdu_req;
  assign accept  = start && (state == IDLE);
  assign mdu_req = ENABLE_MDU && (ctrl[4:3] == 2'b10);

  logic             a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  always_comb begin
    a_signed = (ctrl[2:0] == 3'd1) || (ctrl[2:0] == 3'd2) ||
               (ctrl[2:0] == 3'd4) || (ctrl[2:0] == 3'd6);
    b_signed = (ctrl[2:0] == 3'd1) || (ctrl[2:0] == 3'd4) || (ctrl[2:0] == 3'd6);
    neg_a    = a_signed && a[WIDTH-1];
    neg_b    = b_signed && b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
  end

  logic [WIDTH-1:0] alu_y;
  always_comb begin
    alu_y = '0;
    case (ctrl)
      5'd0: alu_y = a + b;
      5'd1: alu_y = a - b;
      5'd2: alu_y = a & b;
      5'd3: alu_y = a | b;
      5'd4: alu_y = a ^ b;
      5'd5: alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      5'd6: alu_y = {{(WIDTH-1){1'b0}}, a < b};
      5'd7: alu_y = a << b[SW-1:0];
      5'd8: alu_y = a >> b[SW-1:0];
      5'd9: alu_y = $signed(a) >>> b[SW-1:0];
      default: alu_y = '0;
    endcase
  end

  // Multiply: shift-add with multiplier in lo; divide: restoring, dividend
  // shifts out of lo while quotient bits shift in, partial remainder in hi.
  logic [WIDTH:0] sum, rem_next, diff;
  always_comb begin
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    rem_next = {hi, lo[WIDTH-1]};
    diff     = rem_next - {1'b0, mcand};
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s, mdu_y;
  always_comb begin
    prod   = {hi, lo};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo : lo;
    r_s    = neg_r ? -hi : hi;
    mdu_y  = '0;
    if (!op[2])
      mdu_y = (op[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    else if (!op[1])
      mdu_y = b_zero ? '1 : q_s;
    else
      mdu_y = r_s;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && mdu_req) state_next = CALC;
      CALC:    if (cnt == LAST) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y      <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (mdu_req) begin
            op     <= ctrl[2:0];
            neg_q  <= neg_a ^ neg_b;
            neg_r  <= neg_a;
            b_zero <= (b == '0);
            mcand  <= mag_b;
            hi     <= '0;
            lo     <= mag_a;
            cnt    <= '0;
          end else begin
            y    <= alu_y;
            done <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!op[2]) begin
            {hi, lo} <= {sum, lo[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            hi <= diff[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= rem_next[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
        end
        FIN: begin
          y    <= mdu_y;
          done <= 1'b1;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign zero = (y == '0);

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: WIDTH=32 main instance, plus WIDTH=16 and
// ENABLE_MDU=0 instances sharing clock, reset and operand buses.
module tb_alu_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  start_v;
  logic [4:0]  ctrl;
  logic [31:0] a, b;

  logic        busy32, done32, zero32, busy16, done16, zero16, busy0, done0, zero0;
  logic [31:0] y32, y0;
  logic [15:0] y16;
  logic [1:0]  st32, st16, st0;
  logic [2:0]  done_v, busy_v;
  assign done_v = {done0, done16, done32};
  assign busy_v = {busy0, busy16, busy32};

  alu_mdu #(.WIDTH(32), .ENABLE_MDU(1'b1)) u32 (
    .clk(clk), .reset(reset), .start(start_v[0]), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy32), .done(done32), .y(y32), .zero(zero32), .fsm_state(st32));
  alu_mdu #(.WIDTH(16), .ENABLE_MDU(1'b1)) u16 (
    .clk(clk), .reset(reset), .start(start_v[1]), .ctrl(ctrl), .a(a[15:0]), .b(b[15:0]),
    .busy(busy16), .done(done16), .y(y16), .zero(zero16), .fsm_state(st16));
  alu_mdu #(.WIDTH(32), .ENABLE_MDU(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start_v[2]), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy0), .done(done0), .y(y0), .zero(zero0), .fsm_state(st0));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] y_sel(input int sel);
    case (sel)
      0:       return y32;
      1:       return {16'h0, y16};
      default: return y0;
    endcase
  endfunction

  // Issue one op on instance sel; returns at the negedge of the done cycle.
  task automatic run(input int sel, input logic [4:0] c, input logic [31:0] aa,
                     input logic [31:0] bb, output logic [31:0] res, output int lat,
                     output int busy_bad);
    @(negedge clk);
    ctrl = c; a = aa; b = bb; start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    ctrl = 5'($urandom_range(0, 31)); a = $urandom; b = $urandom;
    lat = 1; busy_bad = 0;
    while (done_v[sel] !== 1'b1 && lat < 200) begin
      if (busy_v[sel] !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    res = y_sel(sel);
  endtask

  task automatic op_chk(input string tag, input int sel, input logic [4:0] c,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, busy_bad;
    run(sel, c, aa, bb, res, lat, busy_bad);
    check(tag, res, exp);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy gaps"}, busy_bad, 0);
    check({tag, " busy at done"}, {31'h0, busy_v[sel]}, 0);
  endtask

  initial begin
    logic [31:0] res;
    int lat, done_cnt;

    reset = 1'b1; start_v = '0; ctrl = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset y", y32, 0);
    check("reset zero", {31'h0, zero32}, 1);
    check("reset done", {31'h0, done32}, 0);
    check("reset busy", {31'h0, busy32}, 0);
    check("reset state", {30'h0, st32}, 0);

    op_chk("ADD 5+7", 0, 5'd0, 32'd5, 32'd7, 32'd12, 1);
    check("ADD zero flag", {31'h0, zero32}, 0);
    op_chk("code 31", 0, 5'd31, 32'd5, 32'd7, 32'd0, 1);
    op_chk("SUB 7-7", 0, 5'd1, 32'd7, 32'd7, 32'd0, 1);
    check("SUB zero flag", {31'h0, zero32}, 1);
    op_chk("AND", 0, 5'd2, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
    op_chk("OR", 0, 5'd3, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1);
    op_chk("XOR", 0, 5'd4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
    op_chk("SRA", 0, 5'd9, 32'h80000000, 32'd4, 32'hF8000000, 1);
    op_chk("SRL", 0, 5'd8, 32'h80000000, 32'd4, 32'h08000000, 1);
    op_chk("SLL b=0x24", 0, 5'd7, 32'h00000001, 32'h00000024, 32'h00000010, 1);
    op_chk("SLT -1,1", 0, 5'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    op_chk("SLTU -1,1", 0, 5'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1);

    op_chk("MUL", 0, 5'd16, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 34);
    op_chk("MULH", 0, 5'd17, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
    op_chk("MULHSU", 0, 5'd18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
    op_chk("MULHU", 0, 5'd19, 32'hFFFFFFFF, 32'd2, 32'h00000001, 34);
    op_chk("MUL small", 0, 5'd16, 32'h00001234, 32'h00000010, 32'h00012340, 34);

    op_chk("DIV -7/2", 0, 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    op_chk("REM -7/2", 0, 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    op_chk("DIV 7/-2", 0, 5'd20, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    op_chk("REM 7/-2", 0, 5'd22, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
    op_chk("DIVU 13/0", 0, 5'd21, 32'd13, 32'd0, 32'hFFFFFFFF, 34);
    op_chk("REMU 13/0", 0, 5'd23, 32'd13, 32'd0, 32'd13, 34);
    op_chk("DIV -7/0", 0, 5'd20, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 34);
    op_chk("REM -7/0", 0, 5'd22, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 34);
    op_chk("DIV ovf", 0, 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
    op_chk("REM ovf", 0, 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);

    // start raised mid-operation must be dropped
    @(negedge clk);
    ctrl = 5'd21; a = 32'd100; b = 32'd7; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; lat = 1;
    while (done32 !== 1'b1 && lat < 200) begin
      if (lat == 5) begin ctrl = 5'd0; a = 32'd1; b = 32'd1; start_v[0] = 1'b1; end
      else start_v[0] = 1'b0;
      @(negedge clk);
      lat++;
    end
    start_v[0] = 1'b0;
    check("drop start result", y32, 32'd14);
    check("drop start latency", lat, 34);
    @(negedge clk);
    check("drop start no extra done", {31'h0, done32}, 0);

    // back-to-back: second start in the done cycle
    ctrl = 5'd0; a = 32'd2; b = 32'd3; start_v[0] = 1'b1;
    @(negedge clk);
    check("b2b first done", {31'h0, done32}, 1);
    check("b2b first y", y32, 32'd5);
    ctrl = 5'd1; a = 32'd10; b = 32'd1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b second done", {31'h0, done32}, 1);
    check("b2b second y", y32, 32'd9);

    // reset in cycle 10 of a DIV
    @(negedge clk);
    ctrl = 5'd20; a = 32'd1000; b = 32'd3; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", {31'h0, busy32}, 0);
    check("mid reset y", y32, 0);
    check("mid reset done", {31'h0, done32}, 0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 === 1'b1) done_cnt++;
    end
    check("mid reset no done", done_cnt, 0);

    op_chk("W16 MULHU", 1, 5'd19, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE, 18);
    op_chk("noMDU ADD", 2, 5'd0, 32'd5, 32'd7, 32'd12, 1);
    op_chk("noMDU MUL", 2, 5'd16, 32'd3, 32'd4, 32'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
